disp_scroll_ctrl: RTL and testbench

- Sequencer that sits in front of the 4-digit multiplexed seven-segment driver.
- Holds a 16-nibble message buffer and presents a sliding 4-digit window on the driver's hex3..hex0 and dp_in inputs.
- Advances the window by one digit per scroll tick, either once through the message or looping.
- Lets any client put a message longer than 4 digits on the display through a simple write/start/stop interface.

---
 rtl/disp_scroll_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_disp_scroll_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// disp_scroll_ctrl
//
// Purpose:
//   Scroll sequencer for the 4-digit multiplexed seven-segment driver. It holds
//   a 16-nibble message and shows a sliding 4-digit window on hex3..hex0,
//   where hex3 is the leftmost digit. The window moves one digit per scroll
//   tick. It either makes one pass through the message or loops forever.
//   A decimal point marks the digit that holds the last nibble of the message.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   wr_en          write one message nibble (honoured only while idle)
//   wr_addr[3:0]   message buffer index 0..15
//   wr_data[3:0]   hex nibble to write
//   msg_len[4:0]   message length 1..16, sampled on start
//   loop           1 = scroll forever, 0 = one pass; sampled on start
//   start          single-cycle pulse that begins scrolling
//   stop           single-cycle pulse that aborts scrolling
//   hold           level input; freezes the scroll tick while high
//   hex3..hex0     digits to the display driver
//   dp_in[3:0]     decimal-point enables; dp_in[3] belongs to hex3
//   busy           high while scrolling
//   done           one-cycle pulse when a non-looping pass completes
//
// Every output is decoded from registers only. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module disp_scroll_ctrl #(
  parameter int TICK_DIV = 25000000,
  parameter int TW       = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [4:0] msg_len,
  input  logic       loop,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  output logic [3:0] hex3,
  output logic [3:0] hex2,
  output logic [3:0] hex1,
  output logic [3:0] hex0,
  output logic [3:0] dp_in,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE   = 1'b0,
    SCROLL = 1'b1
  } state_t;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [4:0]    len_q, len_d;
  logic          loop_q, loop_d;
  logic          done_q, done_d;
  logic [3:0]    msg_q [16];

  logic          lenOk;
  logic          tickWrap;
  logic          ptrWrap;
  logic [3:0]    winIdx [4];
  logic [3:0]    lastHit;

  // A start request is only honoured for a length that fits the buffer.
  // tickWrap marks the last count of a scroll period. ptrWrap marks the
  // last message position, so the next step returns ptr to 0.
  assign lenOk    = (msg_len != 5'd0) && (msg_len <= 5'd16);
  assign tickWrap = (tick_q == TICK_LAST);
  assign ptrWrap  = (({1'b0, ptr_q} + 5'd1) == len_q);

  // Next-state logic for the sequencer.
  // In IDLE, a valid start latches the length and loop mode. It also clears
  // the pointer and tick counter. stop always wins over start and over a
  // coincident step. Reaching the end of a single pass returns to IDLE and
  // raises done for one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tick_d  = tick_q;
    len_d   = len_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop && lenOk) begin
          len_d   = msg_len;
          loop_d  = loop;
          ptr_d   = 4'd0;
          tick_d  = '0;
          state_d = SCROLL;
        end
      end
      SCROLL: begin
        if (stop) begin
          state_d = IDLE;
          ptr_d   = 4'd0;
          tick_d  = '0;
        end else if (!hold) begin
          if (tickWrap) begin
            tick_d = '0;
            if (ptrWrap) begin
              ptr_d = 4'd0;
              if (!loop_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              ptr_d = ptr_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers.
  // Reset is asynchronous, so the display goes blank at the moment reset
  // is asserted, even in the middle of a scroll.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      tick_q  <= '0;
      len_q   <= 5'd0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tick_q  <= tick_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  // Message buffer.
  // Writes are accepted only while idle, so a client cannot corrupt the
  // text that is on screen. Reset clears every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        msg_q[i] <= 4'd0;
      end
    end else if (wr_en && (state_q == IDLE)) begin
      msg_q[wr_addr] <= wr_data;
    end
  end

  // Window index for each digit: (ptr + k) mod len.
  // ptr is always below len and k is at most 3, so the raw sum is at most
  // len + 2. A message of length 1 can therefore need up to three
  // subtractions of len. Three conditional subtract stages cover every
  // length from 1 to 16 without a divider. A digit gets its decimal point
  // when its index is the last position of the message.
  always_comb begin
    logic [4:0] sum;
    lastHit = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      sum = {1'b0, ptr_q} + 5'(k);
      if (sum >= len_q) sum = sum - len_q;
      if (sum >= len_q) sum = sum - len_q;
      if (sum >= len_q) sum = sum - len_q;
      winIdx[k]      = sum[3:0];
      lastHit[3 - k] = (sum == (len_q - 5'd1));
    end
  end

  // Output decode.
  // While idle, the display shows the first four buffer entries without
  // decimal points. While scrolling, it shows the sliding window.
  always_comb begin
    if (state_q == SCROLL) begin
      hex3  = msg_q[winIdx[0]];
      hex2  = msg_q[winIdx[1]];
      hex1  = msg_q[winIdx[2]];
      hex0  = msg_q[winIdx[3]];
      dp_in = lastHit;
    end else begin
      hex3  = msg_q[0];
      hex2  = msg_q[1];
      hex1  = msg_q[2];
      hex0  = msg_q[3];
      dp_in = 4'b0000;
    end
  end

  assign busy = (state_q == SCROLL);
  assign done = done_q;

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_disp_scroll_ctrl
//
// Directed bench for disp_scroll_ctrl, built with a short scroll period
// (TICK_DIV = 4). Inputs are driven just after the falling edge. Outputs
// are sampled at the falling edge.
// ---------------------------------------------------------------------------
module tb_disp_scroll_ctrl;

  localparam int TICK_DIV = 4;
  localparam int TW       = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [4:0] msg_len;
  logic       loop;
  logic       start;
  logic       stop;
  logic       hold;
  logic [3:0] hex3, hex2, hex1, hex0;
  logic [3:0] dp_in;
  logic       busy;
  logic       done;

  logic [3:0] model [16];
  int         vectorCount = 0;
  int         missCount   = 0;
  bit         doneSeen    = 1'b0;

  // Free-running clock with a period of 10 time units.
  always #5 clk = ~clk;

  disp_scroll_ctrl #(
    .TICK_DIV(TICK_DIV),
    .TW      (TW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .msg_len(msg_len),
    .loop   (loop),
    .start  (start),
    .stop   (stop),
    .hold   (hold),
    .hex3   (hex3),
    .hex2   (hex2),
    .hex1   (hex1),
    .hex0   (hex0),
    .dp_in  (dp_in),
    .busy   (busy),
    .done   (done)
  );

  // Compares one observed value against the bench's own expectation and
  // counts the comparison.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advances n clock cycles and returns at a falling edge. It also records
  // any done pulse it sees along the way.
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) doneSeen = 1'b1;
    end
  endtask

  // Writes one nibble while idle and mirrors it in the bench model.
  task automatic writeNibble(input logic [3:0] a, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cycle(1);
    wr_en   = 1'b0;
    model[a] = d;
  endtask

  // Issues a one-cycle start pulse with the given length and loop mode.
  task automatic applyStimulus(input logic [4:0] len, input logic lp);
    msg_len = len;
    loop    = lp;
    start   = 1'b1;
    cycle(1);
    start   = 1'b0;
  endtask

  // Bench model of the window: digit k shows model[(p+k) % len].
  function automatic logic [15:0] expWin(input int p, input int len);
    logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      w[15 - 4*k -: 4] = model[(p + k) % len];
    end
    return w;
  endfunction

  function automatic logic [3:0] expDp(input int p, input int len);
    logic [3:0] d;
    for (int k = 0; k < 4; k++) begin
      d[3 - k] = (((p + k) % len) == (len - 1));
    end
    return d;
  endfunction

  function automatic logic [15:0] idleWin();
    return {model[0], model[1], model[2], model[3]};
  endfunction

  task automatic checkWindow(input string tag, input int p, input int len);
    checkOutput({tag, "_win"}, 32'({hex3, hex2, hex1, hex0}), 32'(expWin(p, len)));
    checkOutput({tag, "_dp"}, 32'(dp_in), 32'(expDp(p, len)));
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = 4'd0;
    msg_len = 5'd0;
    loop    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    hold    = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 4'd0;

    // Reset state: everything reads zero.
    cycle(2);
    checkOutput("rst_win", 32'({hex3, hex2, hex1, hex0}), 32'h0);
    checkOutput("rst_dp", 32'(dp_in), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    cycle(1);

    // Scroll 0..9 once through, with loop off.
    for (int i = 0; i < 10; i++) writeNibble(4'(i), 4'(i));
    checkOutput("t1_idle", 32'({hex3, hex2, hex1, hex0}), 32'h0123);
    applyStimulus(5'd10, 1'b0);
    doneSeen = 1'b0;
    checkOutput("t1_busy", 32'(busy), 32'h1);
    checkOutput("t1_entry", 32'({hex3, hex2, hex1, hex0}), 32'h0123);
    checkOutput("t1_entry_dp", 32'(dp_in), 32'h0);
    checkWindow("t1_s0", 0, 10);
    for (int s = 1; s < 10; s++) begin
      cycle(3);
      checkWindow("t1_pre", s - 1, 10);
      cycle(1);
      checkWindow("t1_step", s, 10);
    end
    checkOutput("t1_9012", 32'({hex3, hex2, hex1, hex0}), 32'h9012);
    checkOutput("t1_9012_dp", 32'(dp_in), 32'h8);
    cycle(3);
    checkOutput("t1_nodone_early", 32'(doneSeen), 32'h0);
    checkOutput("t1_busy_late", 32'(busy), 32'h1);
    cycle(1);
    checkOutput("t1_done", 32'(done), 32'h1);
    checkOutput("t1_busy_fall", 32'(busy), 32'h0);
    checkOutput("t1_end_win", 32'({hex3, hex2, hex1, hex0}), 32'h0123);
    cycle(1);
    checkOutput("t1_done_once", 32'(done), 32'h0);

    // Length-2 message "AB" with loop on.
    writeNibble(4'd0, 4'hA);
    writeNibble(4'd1, 4'hB);
    applyStimulus(5'd2, 1'b1);
    doneSeen = 1'b0;
    checkOutput("t2_abab", 32'({hex3, hex2, hex1, hex0}), 32'hABAB);
    checkOutput("t2_abab_dp", 32'(dp_in), 32'h5);
    for (int r = 0; r < 3; r++) begin
      cycle(4);
      checkOutput("t2_baba", 32'({hex3, hex2, hex1, hex0}), 32'hBABA);
      checkOutput("t2_baba_dp", 32'(dp_in), 32'hA);
      cycle(4);
      checkOutput("t2_abab2", 32'({hex3, hex2, hex1, hex0}), 32'hABAB);
    end
    checkOutput("t2_no_done", 32'(doneSeen), 32'h0);
    checkOutput("t2_still_busy", 32'(busy), 32'h1);
    stop = 1'b1;
    cycle(1);
    stop = 1'b0;
    checkOutput("t2_stopped", 32'(busy), 32'h0);

    // Length-1 message with loop off.
    writeNibble(4'd0, 4'h7);
    applyStimulus(5'd1, 1'b0);
    checkOutput("t3_7777", 32'({hex3, hex2, hex1, hex0}), 32'h7777);
    checkOutput("t3_dp", 32'(dp_in), 32'hF);
    checkOutput("t3_busy", 32'(busy), 32'h1);
    cycle(3);
    checkOutput("t3_done_early", 32'(done), 32'h0);
    cycle(1);
    checkOutput("t3_done", 32'(done), 32'h1);
    checkOutput("t3_busy_fall", 32'(busy), 32'h0);
    checkOutput("t3_idle", 32'({hex3, hex2, hex1, hex0}), 32'h7B23);

    // Hold mid-scroll, with a write attempted while scrolling.
    applyStimulus(5'd10, 1'b1);
    cycle(2);
    hold    = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = 4'hF;
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      checkOutput("t4_hold", 32'({hex3, hex2, hex1, hex0}), 32'h7B23);
    end
    wr_en = 1'b0;
    hold  = 1'b0;
    cycle(1);
    checkOutput("t4_after1", 32'({hex3, hex2, hex1, hex0}), 32'h7B23);
    cycle(1);
    checkOutput("t4_step", 32'({hex3, hex2, hex1, hex0}), 32'hB234);
    stop = 1'b1;
    cycle(1);
    stop = 1'b0;
    checkOutput("t4_idle_busy", 32'(busy), 32'h0);
    checkOutput("t4_buf_kept", 32'({hex3, hex2, hex1, hex0}), 32'h7B23);

    // stop coincides with the completion step: no done pulse.
    doneSeen = 1'b0;
    applyStimulus(5'd1, 1'b0);
    cycle(3);
    stop = 1'b1;
    cycle(1);
    stop = 1'b0;
    checkOutput("t5_busy", 32'(busy), 32'h0);
    cycle(2);
    checkOutput("t5_no_done", 32'(doneSeen), 32'h0);
    msg_len = 5'd4;
    start   = 1'b1;
    stop    = 1'b1;
    cycle(1);
    start   = 1'b0;
    stop    = 1'b0;
    checkOutput("t5_startstop", 32'(busy), 32'h0);
    applyStimulus(5'd0, 1'b0);
    checkOutput("t5_len0", 32'(busy), 32'h0);
    applyStimulus(5'd17, 1'b0);
    checkOutput("t5_len17", 32'(busy), 32'h0);

    // Asynchronous reset mid-scroll.
    applyStimulus(5'd10, 1'b1);
    cycle(5);
    checkOutput("t6_busy_pre", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("t6_async_win", 32'({hex3, hex2, hex1, hex0}), 32'h0);
    checkOutput("t6_async_dp", 32'(dp_in), 32'h0);
    checkOutput("t6_async_busy", 32'(busy), 32'h0);
    cycle(1);
    reset = 1'b0;
    cycle(1);
    checkOutput("t6_buf_cleared", 32'({hex3, hex2, hex1, hex0}), 32'h0);
    checkOutput("t6_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
